// File: rtl/alu_issue_stage.sv
// Issue stage for a combinational ALU. Buffers commands in a FIFO, holds operands stable for
// one settle cycle, then registers the result and offers it on a valid/ready response port.
module alu_issue_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [WIDTH-1:0]           cmd_a,
  input  logic [WIDTH-1:0]           cmd_b,
  input  logic [SEL_W-1:0]           cmd_sel,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [SEL_W-1:0]           alu_sel,
  input  logic [WIDTH-1:0]           alu_out,
  input  logic                       alu_carry,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_out,
  output logic                       rsp_carry,
  output logic [SEL_W-1:0]           rsp_sel,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [15:0]                ops_done
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] mem_a   [DEPTH];
  logic [WIDTH-1:0] mem_b   [DEPTH];
  logic [SEL_W-1:0] mem_sel [DEPTH];

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [SEL_W-1:0] alu_sel_q;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_out_q;
  logic             rsp_carry_q;
  logic [SEL_W-1:0] rsp_sel_q;
  logic [15:0]      ops_done_q;

  logic push, pop, capture, done_inc, not_empty;

  assign not_empty = (count_q != '0);
  // Ready is gated by rst_n so nothing is offered while the block is held in reset.
  assign cmd_ready = rst_n && (count_q != Full);
  assign push      = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    pop         = 1'b0;
    capture     = 1'b0;
    done_inc    = 1'b0;
    case (state_q)
      StIdle: begin
        if (not_empty) begin
          pop     = 1'b1;
          state_d = StDrive;
        end
      end
      StDrive: begin
        capture     = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_valid_q && rsp_ready) begin
          done_inc    = 1'b1;
          rsp_valid_d = 1'b0;
          if (not_empty) begin
            pop     = 1'b1;
            state_d = StDrive;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q]   <= cmd_a;
      mem_b[wr_ptr_q]   <= cmd_b;
      mem_sel[wr_ptr_q] <= cmd_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_sel_q   <= '0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        alu_a_q   <= mem_a[rd_ptr_q];
        alu_b_q   <= mem_b[rd_ptr_q];
        alu_sel_q <= mem_sel[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + PW'(1);
      end
      if (capture) begin
        rsp_out_q   <= alu_out;
        rsp_carry_q <= alu_carry;
        rsp_sel_q   <= alu_sel_q;
      end
      if (done_inc) begin
        ops_done_q <= ops_done_q + 16'd1;
      end
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_out    = rsp_out_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_sel    = rsp_sel_q;
  assign fifo_count = count_q;
  assign ops_done   = ops_done_q;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Command-issue stage that sits directly upstream of the combinational `alu` and also captures its result. It buffers operand commands in a small FIFO, drives one command at a time onto the ALU's A/B/ALU_sel inputs, and holds those inputs stable for a full settle cycle. It then registers ALU_out/Carry_out and presents them, tagged with the opcode, through a valid/ready response port. Its presence lets the ALU be exercised by back-to-back traffic instead of hand-sequenced stimulus.

## Interface
- `WIDTH`, 8: operand/result width; matches ALU A, B and ALU_out.
- `SEL_W`, 4: opcode width; matches ALU_sel.
- `DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals (count != DEPTH); forced 0 while rst_n low.
- `cmd_a`, `cmd_b`  in  WIDTH  operands.
- `cmd_sel`  in  SEL_W  opcode.
- `alu_a`, `alu_b`  out  WIDTH  registered, to ALU A/B.
- `alu_sel`  out  SEL_W  registered, to ALU ALU_sel.
- `alu_out`  in  WIDTH  from ALU ALU_out.
- `alu_carry`  in  1  from ALU Carry_out.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_out`  out  WIDTH  captured ALU_out.
- `rsp_carry`  out  1  captured Carry_out.
- `rsp_sel`  out  SEL_W  opcode that produced the response.
- `fifo_count`  out  $clog2(DEPTH+1)  commands buffered, not yet issued.
- `ops_done`  out  16  completed response handshakes; wraps 0xFFFF→0x0000.

## Operation
- Push: `cmd_valid && cmd_ready` at an edge writes {a, b, sel} at the write pointer. The write pointer then advances modulo DEPTH.
- Pop: performed only by the FSM. The head moves into alu_a/alu_b/alu_sel and the read pointer advances modulo DEPTH.
- Push and pop in the same cycle: both happen and fifo_count is unchanged.
  - When full, cmd_ready is 0, so no push happens even if a pop occurs that cycle.
- FSM states IDLE, DRIVE, RESP; reset state is IDLE.
  - IDLE: if fifo_count != 0, pop and go to DRIVE; otherwise stay.
  - DRIVE: exactly one cycle with operands stable. At its closing edge, capture alu_out→rsp_out, alu_carry→rsp_carry, alu_sel→rsp_sel; set rsp_valid; go to RESP.
  - RESP: hold rsp_* and rsp_valid until `rsp_valid && rsp_ready`. On that handshake, increment ops_done.
    - If fifo_count != 0 at that edge, pop in the same edge and go to DRIVE; rsp_valid drops for one cycle.
    - Otherwise clear rsp_valid and go to IDLE.
- A command pushed at the same edge that RESP completes with an empty FIFO is not popped at that edge. It is popped from IDLE next cycle.
- alu_a/alu_b/alu_sel change only on a pop; they keep their last values in IDLE and RESP.
- rsp_out/rsp_carry/rsp_sel change only at the DRIVE→RESP edge, so they are stable whenever rsp_valid is 1.
- No arithmetic inside the block; the ALU result is passed through at full width unchanged.

## Timing
- Reset (rst_n low, asynchronous):
  - FIFO pointers 0, fifo_count 0, FSM IDLE.
  - alu_a 0, alu_b 0, alu_sel 0.
  - rsp_valid 0, rsp_out 0, rsp_carry 0, rsp_sel 0.
  - ops_done 0, cmd_ready 0.
- Reset release: cmd_ready is 1 in the first cycle after rst_n rises.
- Latency: command accepted at edge E into an empty, IDLE stage → operands driven after E+1 → rsp_valid high after E+2.
- Throughput with rsp_ready held 1: one response per 2 cycles.
- Reset mid-operation: buffered commands and any pending response are discarded; no partial response is emitted after release.
- rsp_ready low: the stage stalls in RESP; the FIFO keeps filling until cmd_ready drops at fifo_count == DEPTH.

## Test plan
- Single op: reset, push a=0x12, b=0x34, sel=0 with rsp_ready=1 → rsp_valid 2 edges later; rsp_out=0x46, rsp_carry=0, rsp_sel=0, ops_done=1.
- Carry: push a=0xFF, b=0x01, sel=0 → rsp_out=0x00, rsp_carry=1; then push a=0x05, b=0x07, sel=1 → rsp_out=0xFE, rsp_sel=1.
- Back-pressure/full: rsp_ready=0, push 6 commands back-to-back.
  - Expect 1 issued into DRIVE/RESP and 4 buffered, after which cmd_ready=0 at fifo_count=4; the 6th is held off.
  - Raise rsp_ready → 5 responses emerge in push order, each one cycle apart in valid pulses every 2 cycles.
- Same-edge push/pop: at fifo_count=4 with the stage in RESP, assert rsp_ready and cmd_valid together → the pop occurs, no push, fifo_count=3, cmd_ready=1 next cycle.
- Wrap: 2·DEPTH+1 sequential commands with distinct operands → all results correct and ordered across pointer wrap; ops_done=9.
- Async reset: assert rst_n low mid-DRIVE with 3 commands buffered → all outputs immediately at reset values; after release, no response appears without new commands.
